// File: rtl/demux_pkg.sv
// Shared types and constants for the demux scheduler.
// Holds data width, channel count, FSM state enum and channel-select type.
package demux_pkg;

   localparam int DATA_W = 64;
   localparam int N_OUT  = 4;

   typedef logic [1:0] chan_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Round-robin successor; the 2-bit type wraps 3 -> 0.
   function automatic chan_t rr_next(input chan_t p);
      return p + chan_t'(1);
   endfunction

endpackage

// File: rtl/demux_obuf.sv
// One-entry output buffer for a single demux channel.
// Ports: clk, rst, load/load_data (fill), ready (drain), valid/data (out).
module demux_obuf #(
   parameter int DATA_W = demux_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              full;
   logic [DATA_W-1:0] held;

   // A load wins over a drain at the same edge: the consumer takes the
   // old beat while the new one is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         held <= '0;
      end else if (load) begin
         full <= 1'b1;
         held <= load_data;
      end else if (full && ready) begin
         full <= 1'b0;
         held <= '0;
      end
   end

   assign valid = full;
   assign data  = full ? held : '0;

endmodule

// File: rtl/demux_sched.sv
// Packet demultiplexer: routes beats to 4 one-entry channel buffers,
// by fixed destination (mode=0) or strict round-robin per packet (mode=1).
// Ports: clk, rst, mode, in_* (upstream beat), out_* (per channel),
// busy (packet in progress), sel (channel for the current/next beat).
module demux_sched #(
   parameter int DATA_W = demux_pkg::DATA_W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               mode,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [DATA_W-1:0]                  in_data,
   input  logic [1:0]                         in_dest,
   input  logic                               in_last,
   output logic [demux_pkg::N_OUT-1:0]        out_valid,
   input  logic [demux_pkg::N_OUT-1:0]        out_ready,
   output logic [demux_pkg::N_OUT*DATA_W-1:0] out_data,
   output logic                               busy,
   output logic [1:0]                         sel
);

   import demux_pkg::*;

   state_t              state;
   chan_t               burst_sel;
   chan_t               rr_ptr;
   logic                burst_mode;
   logic                accept;
   logic                pkt_mode;
   logic [N_OUT-1:0]    load;
   logic [DATA_W-1:0]   buf_data [N_OUT];

   // Inside a packet the channel is frozen; between packets it follows
   // either in_dest or the rotation pointer.
   always_comb begin
      sel = rr_ptr;
      if (state == BURST)
         sel = burst_sel;
      else if (!mode)
         sel = in_dest;
   end

   // Strict rotation: only the selected channel is considered, so a full
   // target stalls the input instead of skipping ahead.
   assign in_ready = ~out_valid[sel] | out_ready[sel];
   assign accept   = in_valid & in_ready;
   assign busy     = (state == BURST);

   // Mode of the packet owning the current beat, captured at its first beat.
   assign pkt_mode = (state == BURST) ? burst_mode : mode;

   always_comb begin
      load = '0;
      if (accept)
         load[sel] = 1'b1;
   end

   for (genvar g = 0; g < N_OUT; g++) begin : g_ch
      demux_obuf #(
         .DATA_W(DATA_W)
      ) u_obuf (
         .clk      (clk),
         .rst      (rst),
         .load     (load[g]),
         .load_data(in_data),
         .ready    (out_ready[g]),
         .valid    (out_valid[g]),
         .data     (buf_data[g])
      );
      assign out_data[g*DATA_W +: DATA_W] = buf_data[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         burst_sel  <= '0;
         burst_mode <= 1'b0;
         rr_ptr     <= '0;
      end else if (accept) begin
         unique case (state)
            IDLE: begin
               if (!in_last) begin
                  state      <= BURST;
                  burst_sel  <= sel;
                  burst_mode <= mode;
               end
            end
            BURST: begin
               if (in_last)
                  state <= IDLE;
            end
         endcase
         if (in_last && pkt_mode)
            rr_ptr <= rr_next(rr_ptr);
      end
   end

endmodule

// File: tb/tb_demux_sched.sv
// Directed, table-driven bench for demux_sched.
// Each vector drives inputs mid-cycle and checks outputs before the edge.
module tb_demux_sched;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    in_dest;
   logic          in_last;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [4*W-1:0] out_data;
   logic          busy;
   logic [1:0]    sel;

   demux_sched #(
      .DATA_W(W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_dest  (in_dest),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy),
      .sel      (sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rst;
      logic         mode;
      logic         vld;
      logic [W-1:0] dat;
      logic [1:0]   dest;
      logic         last;
      logic [3:0]   ordy;
      logic         e_rdy;
      logic [3:0]   e_ov;
      logic         e_busy;
      logic [1:0]   e_sel;
      logic [4*W-1:0] e_od;
   } vec_t;

   int n_vec  = 0;
   int n_miss = 0;
   vec_t tbl[$];

   function automatic logic [4*W-1:0] od(input logic [W-1:0] d0,
                                         input logic [W-1:0] d1,
                                         input logic [W-1:0] d2,
                                         input logic [W-1:0] d3);
      return {d3, d2, d1, d0};
   endfunction

   function automatic vec_t mk(input string nm, input logic r,
                               input logic m, input logic v,
                               input logic [W-1:0] d, input logic [1:0] ds,
                               input logic l, input logic [3:0] orr,
                               input logic er, input logic [3:0] eov,
                               input logic eb, input logic [1:0] es,
                               input logic [4*W-1:0] eod);
      vec_t x;
      x.name = nm; x.rst = r; x.mode = m; x.vld = v; x.dat = d;
      x.dest = ds; x.last = l; x.ordy = orr; x.e_rdy = er;
      x.e_ov = eov; x.e_busy = eb; x.e_sel = es; x.e_od = eod;
      return x;
   endfunction

   task automatic apply(input vec_t x);
      @(negedge clk);
      rst       = x.rst;
      mode      = x.mode;
      in_valid  = x.vld;
      in_data   = x.dat;
      in_dest   = x.dest;
      in_last   = x.last;
      out_ready = x.ordy;
      #1;
      n_vec++;
      if ({in_ready, out_valid, busy, sel, out_data} !==
          {x.e_rdy, x.e_ov, x.e_busy, x.e_sel, x.e_od}) begin
         n_miss++;
         $display("FAIL %s: got rdy=%b ov=%b busy=%b sel=%0d od=%h want rdy=%b ov=%b busy=%b sel=%0d od=%h",
                  x.name, in_ready, out_valid, busy, sel, out_data,
                  x.e_rdy, x.e_ov, x.e_busy, x.e_sel, x.e_od);
      end
   endtask

   logic [W-1:0] z;

   initial begin
      z = '0;
      rst = 1'b1; mode = 1'b1; in_valid = 1'b0; in_data = '0;
      in_dest = 2'd0; in_last = 1'b0; out_ready = 4'hF;
      repeat (2) @(posedge clk);

      // reset state, then round-robin of four single-beat packets
      tbl.push_back(mk("rst_state", 0,1,0,z,0,0,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));
      tbl.push_back(mk("rr_a0", 0,1,1,'hA0,0,1,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));
      tbl.push_back(mk("rr_a1", 0,1,1,'hA1,0,1,4'hF, 1,4'b0001,0,1, od('hA0,z,z,z)));
      tbl.push_back(mk("rr_a2", 0,1,1,'hA2,0,1,4'hF, 1,4'b0010,0,2, od(z,'hA1,z,z)));
      tbl.push_back(mk("rr_a3", 0,1,1,'hA3,0,1,4'hF, 1,4'b0100,0,3, od(z,z,'hA2,z)));
      tbl.push_back(mk("rr_out3", 0,1,0,z,0,0,4'hF, 1,4'b1000,0,0, od(z,z,z,'hA3)));
      tbl.push_back(mk("rr_wrap", 0,1,0,z,0,0,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));
      // fixed-destination burst, in_dest changes after the first beat
      tbl.push_back(mk("fix_b1", 0,0,1,'h11,2,0,4'hF, 1,4'b0000,0,2, od(z,z,z,z)));
      tbl.push_back(mk("fix_b2", 0,0,1,'h22,1,0,4'hF, 1,4'b0100,1,2, od(z,z,'h11,z)));
      tbl.push_back(mk("fix_b3", 0,0,1,'h33,1,1,4'hF, 1,4'b0100,1,2, od(z,z,'h22,z)));
      tbl.push_back(mk("fix_idle", 0,0,0,z,1,0,4'hF, 1,4'b0100,0,1, od(z,z,'h33,z)));
      tbl.push_back(mk("fix_rrhold", 0,1,0,z,1,0,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));
      // drain and reload of ch1 at the same edge
      tbl.push_back(mk("dl_b1", 0,0,1,'hB1,1,1,4'hF, 1,4'b0000,0,1, od(z,z,z,z)));
      tbl.push_back(mk("dl_b2", 0,0,1,'hB2,1,1,4'hF, 1,4'b0010,0,1, od(z,'hB1,z,z)));
      tbl.push_back(mk("dl_new", 0,0,0,z,1,0,4'hF, 1,4'b0010,0,1, od(z,'hB2,z,z)));

      foreach (tbl[i]) apply(tbl[i]);

      // strict rotation stalls on full ch0 instead of skipping to ch1
      apply(mk("st_p1", 0,1,1,'h01,0,1,4'hE, 1,4'b0000,0,0, od(z,z,z,z)));
      apply(mk("st_f1", 0,1,1,'h02,0,1,4'hE, 1,4'b0001,0,1, od('h01,z,z,z)));
      apply(mk("st_f2", 0,1,1,'h03,0,1,4'hE, 1,4'b0011,0,2, od('h01,'h02,z,z)));
      apply(mk("st_f3", 0,1,1,'h04,0,1,4'hE, 1,4'b0101,0,3, od('h01,z,'h03,z)));
      apply(mk("st_stall", 0,1,1,'h05,0,1,4'hE, 0,4'b1001,0,0, od('h01,z,z,'h04)));
      apply(mk("st_release", 0,1,1,'h05,0,1,4'hF, 1,4'b0001,0,0, od('h01,z,z,z)));
      apply(mk("st_loaded", 0,1,0,z,0,0,4'hF, 1,4'b0001,0,1, od('h05,z,z,z)));
      apply(mk("st_empty", 0,1,0,z,0,0,4'hF, 1,4'b0000,0,1, od(z,z,z,z)));

      // reset in the middle of a burst with every buffer full
      apply(mk("rb_d1", 0,1,1,'hD1,0,1,4'h0, 1,4'b0000,0,1, od(z,z,z,z)));
      apply(mk("rb_d2", 0,1,1,'hD2,0,1,4'h0, 1,4'b0010,0,2, od(z,'hD1,z,z)));
      apply(mk("rb_d3", 0,1,1,'hD3,0,1,4'h0, 1,4'b0110,0,3, od(z,'hD1,'hD2,z)));
      apply(mk("rb_d0", 0,1,1,'hD0,0,0,4'h0, 1,4'b1110,0,0, od(z,'hD1,'hD2,'hD3)));
      apply(mk("rb_full", 0,1,1,'hE0,0,0,4'h0, 0,4'b1111,1,0, od('hD0,'hD1,'hD2,'hD3)));
      apply(mk("rb_rst", 1,1,1,'hE0,0,0,4'hF, 1,4'b1111,1,0, od('hD0,'hD1,'hD2,'hD3)));
      apply(mk("rb_after", 0,1,0,z,0,0,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));

      // mode flips to 0 mid-packet: latched channel, one rr step, then in_dest
      apply(mk("mt_f0", 0,1,1,'hF0,3,0,4'hF, 1,4'b0000,0,0, od(z,z,z,z)));
      apply(mk("mt_f1", 0,0,1,'hF1,3,0,4'hF, 1,4'b0001,1,0, od('hF0,z,z,z)));
      apply(mk("mt_f2", 0,0,1,'hF2,3,1,4'hF, 1,4'b0001,1,0, od('hF1,z,z,z)));
      apply(mk("mt_f3", 0,0,1,'hF3,3,1,4'hF, 1,4'b0001,0,3, od('hF2,z,z,z)));
      apply(mk("mt_rr1", 0,1,0,z,3,0,4'hF, 1,4'b1000,0,1, od(z,z,z,'hF3)));
      apply(mk("mt_end", 0,1,0,z,3,0,4'hF, 1,4'b0000,0,1, od(z,z,z,z)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
